// File: rtl/piccolo_pkg.sv
// Shared constants and GF(2^4) helpers for the Piccolo diffusion datapath.
// Field polynomial is x^4+x+1; matrix coefficients are only ever 1, 2 or 3.
package piccolo_pkg;

  localparam logic MODE_M = 1'b0;
  localparam logic MODE_F = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
    4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd
  };

  localparam logic [3:0] M_ROW [4][4] = '{
    '{4'd2, 4'd3, 4'd1, 4'd1},
    '{4'd1, 4'd2, 4'd3, 4'd1},
    '{4'd1, 4'd1, 4'd2, 4'd3},
    '{4'd3, 4'd1, 4'd1, 4'd2}
  };

  function automatic logic [3:0] gf16_mul2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] coef, input logic [3:0] x);
    logic [3:0] r;
    case (coef)
      4'd1:    r = x;
      4'd2:    r = gf16_mul2(x);
      4'd3:    r = gf16_mul2(x) ^ x;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sbox_word(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      r[4*n +: 4] = SBOX[w[4*n +: 4]];
    end
    return r;
  endfunction

endpackage

// File: rtl/piccolo_row_unit.sv
// One row of the Piccolo matrix applied to a 16-bit word (nibble x0 in bits 15:12).
module piccolo_row_unit
  import piccolo_pkg::*;
(
  input  logic [15:0] word,
  input  logic [1:0]  row,
  output logic [3:0]  y_row
);

  always_comb begin
    y_row = 4'h0;
    for (int j = 0; j < 4; j++) begin
      y_row = y_row ^ gf16_mul(M_ROW[row][j], word[12-4*j +: 4]);
    end
  end

endmodule

// File: rtl/piccolo_diffusion_engine.sv
// Handshaked Piccolo diffusion engine: M*A or S(M(S(A))) on LANES independent 16-bit words.
// Rows are computed one per cycle (SERIAL=1) or all at once (SERIAL=0) from a latched word.
module piccolo_diffusion_engine
  import piccolo_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int SERIAL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [16*LANES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*LANES-1:0] out_data,
  output state_e              dbg_state
);

  localparam int W = 16 * LANES;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         mode_q;
  logic [W-1:0] latch_q, latch_d;
  logic [W-1:0] out_q, out_d;
  logic         accept;
  logic [3:0]   y_ser [LANES];
  logic [3:0]   y_par [LANES][4];

  // Handshake: a transfer happens on a posedge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out_data is held until taken.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready && in_valid;
  assign out_data  = out_q;
  assign dbg_state = state_q;

  // Mode F stores S(A) so every row reads the same stable substituted word.
  always_comb begin
    latch_d = in_data;
    if (in_mode == MODE_F) begin
      for (int l = 0; l < LANES; l++) begin
        latch_d[16*l +: 16] = sbox_word(in_data[16*l +: 16]);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (SERIAL != 0) begin : g_ser
      piccolo_row_unit u_row (
        .word  (latch_q[16*l +: 16]),
        .row   (cnt_q),
        .y_row (y_ser[l])
      );
      for (genvar r = 0; r < 4; r++) begin : g_tie
        assign y_par[l][r] = 4'h0;
      end
    end else begin : g_par
      for (genvar r = 0; r < 4; r++) begin : g_row
        piccolo_row_unit u_row (
          .word  (latch_q[16*l +: 16]),
          .row   (2'(r)),
          .y_row (y_par[l][r])
        );
      end
      assign y_ser[l] = 4'h0;
    end
  end

  always_comb begin
    out_d = out_q;
    for (int l = 0; l < LANES; l++) begin
      if (SERIAL != 0) begin
        out_d[16*l + 12 - 4*int'(cnt_q) +: 4] =
          (mode_q == MODE_F) ? SBOX[y_ser[l]] : y_ser[l];
      end else begin
        for (int r = 0; r < 4; r++) begin
          out_d[16*l + 12 - 4*r +: 4] =
            (mode_q == MODE_F) ? SBOX[y_par[l][r]] : y_par[l][r];
        end
      end
    end
  end

  // The parallel build still spends one BUSY cycle computing from the latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (SERIAL != 0) begin
          if (cnt_q == 2'd3) begin
            state_d = DONE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = 2'(cnt_q + 2'd1);
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      mode_q  <= MODE_M;
      latch_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        latch_q <= latch_d;
        mode_q  <= in_mode;
      end
      if (state_q == BUSY) out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_piccolo_diffusion_engine.sv
// Directed bench: a two-lane serial engine and a one-lane parallel engine
// checked against hand-computed Piccolo diffusion results.
module tb_piccolo_diffusion_engine;
  import piccolo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  state_e      s_dbg;

  logic        p_in_valid, p_in_ready, p_in_mode, p_out_valid, p_out_ready;
  logic [15:0] p_in_data, p_out_data;
  state_e      p_dbg;

  int compared   = 0;
  int mismatched = 0;

  piccolo_diffusion_engine #(.LANES(2), .SERIAL(1)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_mode   (s_in_mode),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .dbg_state (s_dbg)
  );

  piccolo_diffusion_engine #(.LANES(1), .SERIAL(0)) dut_p (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .in_mode   (p_in_mode),
    .in_data   (p_in_data),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .out_data  (p_out_data),
    .dbg_state (p_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_s(input logic mode, input logic [31:0] data, input logic [31:0] exp,
                       input string tag, input int hold);
    int lat;
    check({tag, "/ready"}, 32'(s_in_ready), 32'd1);
    s_in_valid = 1'b1;
    s_in_mode  = mode;
    s_in_data  = data;
    tick();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      s_in_mode = ~s_in_mode;
      s_in_data = $urandom();
      tick();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd4);
    check({tag, "/data"}, s_out_data, exp);
    for (int i = 0; i < hold; i++) begin
      s_in_data = $urandom();
      tick();
      check({tag, "/hold_data"}, s_out_data, exp);
      check({tag, "/hold_ready"}, 32'(s_in_ready), 32'd0);
    end
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    check({tag, "/back_idle"}, 32'(s_in_ready), 32'd1);
  endtask

  task automatic run_p(input logic mode, input logic [15:0] data, input logic [15:0] exp,
                       input string tag);
    int lat;
    check({tag, "/ready"}, 32'(p_in_ready), 32'd1);
    p_in_valid = 1'b1;
    p_in_mode  = mode;
    p_in_data  = data;
    tick();
    p_in_valid = 1'b0;
    lat = 0;
    while (!p_out_valid && lat < 20) begin
      p_in_mode = ~p_in_mode;
      p_in_data = 16'($urandom());
      tick();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd1);
    check({tag, "/data"}, 32'(p_out_data), 32'(exp));
    p_out_ready = 1'b1;
    tick();
    p_out_ready = 1'b0;
    check({tag, "/back_idle"}, 32'(p_in_ready), 32'd1);
  endtask

  initial begin
    int pulses, first, last;
    rst_n = 1'b0;
    s_in_valid = 1'b0; s_in_mode = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_mode = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
    tick();
    tick();
    check("reset/s_out_valid", 32'(s_out_valid), 32'd0);
    check("reset/s_in_ready", 32'(s_in_ready), 32'd1);
    check("reset/s_out_data", s_out_data, 32'h0);
    check("reset/s_state", 32'(s_dbg), 32'(IDLE));
    check("reset/p_out_valid", 32'(p_out_valid), 32'd0);
    check("reset/p_state", 32'(p_dbg), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    run_s(MODE_M, 32'h0001_1000, 32'h1132_2113, "t1_unit", 0);
    run_s(MODE_M, 32'h0000_0001, 32'h0000_1132, "t1_x3", 0);
    run_s(MODE_M, 32'h0000_a1c7, 32'h0000_f89e, "t2_serial", 0);
    run_p(MODE_M, 16'ha1c7, 16'hf89e, "t2_par");
    run_p(MODE_M, 16'h1000, 16'h2113, "t2_par_unit");
    run_s(MODE_F, 32'h0000_0000, 32'h5555_5555, "t3_f_zero", 0);
    run_s(MODE_M, 32'h0000_0000, 32'h0000_0000, "t3_m_zero", 0);
    run_p(MODE_F, 16'h0000, 16'h5555, "t3_par_f_zero");
    run_s(MODE_F, 32'h0000_1000, 32'h5555_a332, "t3_f_unit", 0);
    run_p(MODE_F, 16'h1000, 16'ha332, "t3_par_f_unit");
    run_s(MODE_M, 32'h1000_a1c7, 32'h2113_f89e, "t4_lanes", 5);

    // Abort a transaction with the row counter at 2.
    s_in_valid = 1'b1; s_in_mode = MODE_M; s_in_data = 32'h1000_a1c7;
    tick();
    s_in_valid = 1'b0;
    tick();
    tick();
    check("t5/busy", 32'(s_dbg), 32'(BUSY));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5/out_valid", 32'(s_out_valid), 32'd0);
    check("t5/in_ready", 32'(s_in_ready), 32'd1);
    check("t5/out_data", s_out_data, 32'h0);
    run_s(MODE_M, 32'h0001_0100, 32'h1132_3211, "t5_after", 0);

    // Back-to-back serial: in_ready should reappear every 6 cycles.
    pulses = 0; first = 0; last = 0;
    s_in_valid = 1'b1; s_in_mode = MODE_M; s_in_data = 32'h0001_1000; s_out_ready = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (s_out_valid) check("t6_s/data", s_out_data, 32'h1132_2113);
      if (s_in_ready) begin
        pulses++;
        if (first == 0) first = i;
        last = i;
      end
    end
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    check("t6_s/pulses", 32'(pulses), 32'd3);
    check("t6_s/first", 32'(first), 32'd6);
    check("t6_s/last", 32'(last), 32'd18);

    // Back-to-back parallel: every 3 cycles.
    pulses = 0; first = 0; last = 0;
    p_in_valid = 1'b1; p_in_mode = MODE_M; p_in_data = 16'ha1c7; p_out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (p_out_valid) check("t6_p/data", 32'(p_out_data), 32'h0000_f89e);
      if (p_in_ready) begin
        pulses++;
        if (first == 0) first = i;
        last = i;
      end
    end
    p_in_valid = 1'b0; p_out_ready = 1'b0;
    check("t6_p/pulses", 32'(pulses), 32'd3);
    check("t6_p/first", 32'(first), 32'd3);
    check("t6_p/last", 32'(last), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
